// File: rtl/fft_pkg.sv
// Shared FFT definitions: controller state encoding, default sizes and the
// butterfly pair / twiddle index mapping used by the controller, RAM and ROM.
package fft_pkg;

    localparam int FFT_N_DEF    = 512;
    localparam int FFT_LMAX_DEF = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } bf_state_t;

    typedef struct packed {
        logic [31:0] add1;
        logic [31:0] add2;
        logic [31:0] tw;
    } bf_pair_t;

    // Butterfly j of stage s: inputs sit 2^s apart inside groups of 2^(s+1).
    function automatic bf_pair_t bf_pair(input logic [31:0] s, input logic [31:0] j,
                                         input logic [31:0] l_max);
        bf_pair_t    p;
        logic [31:0] low_mask;
        low_mask = (32'd1 << s) - 32'd1;
        p.add1   = ((j >> s) << (s + 32'd1)) + (j & low_mask);
        p.add2   = p.add1 + (32'd1 << s);
        p.tw     = (j & low_mask) << (l_max - 32'd1 - s);
        return p;
    endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational (stage, butterfly) -> read pair and twiddle index mapping.
module fft_bf_addr_gen
    import fft_pkg::*;
#(
    parameter int L_max = FFT_LMAX_DEF
) (
    input  logic [3:0]       s,
    input  logic [L_max-2:0] j,
    output logic [L_max-1:0] add1,
    output logic [L_max-1:0] add2,
    output logic [L_max-2:0] tw_addr
);

    bf_pair_t pair;

    always_comb begin
        pair    = bf_pair(32'(s), 32'(j), 32'(L_max));
        add1    = L_max'(pair.add1);
        add2    = L_max'(pair.add2);
        tw_addr = (L_max-1)'(pair.tw);
    end

endmodule

// File: rtl/fft_bf_ctrl.sv
// In-place radix-2 DIT FFT sequencer: read pair, wait for the butterfly
// datapath, write the pair back, advance; pulses wd_finish after the last stage.
module fft_bf_ctrl
    import fft_pkg::*;
#(
    parameter int N      = FFT_N_DEF,
    parameter int L_max  = FFT_LMAX_DEF,
    parameter int BF_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             initial_flag,
    output logic             rd_en,
    output logic [L_max-1:0] rd_add1,
    output logic [L_max-1:0] rd_add2,
    output logic [L_max-2:0] tw_addr,
    output logic             wr_en,
    output logic [L_max-1:0] wr_add1,
    output logic [L_max-1:0] wr_add2,
    output logic             wd_finish,
    output logic             busy,
    output logic [3:0]       stage
);

    localparam logic [L_max-2:0] J_LAST    = (L_max-1)'(N / 2 - 1);
    localparam logic [3:0]       S_LAST    = 4'(L_max - 1);
    localparam logic [3:0]       WAIT_LAST = 4'(BF_LAT - 2);

    bf_state_t        state_reg;
    logic [3:0]       s_reg;
    logic [L_max-2:0] j_reg;
    logic [3:0]       wait_cnt_reg;

    logic             rd_en_reg;
    logic [L_max-1:0] rd_add1_reg;
    logic [L_max-1:0] rd_add2_reg;
    logic [L_max-2:0] tw_addr_reg;
    logic             wr_en_reg;
    logic [L_max-1:0] wr_add1_reg;
    logic [L_max-1:0] wr_add2_reg;
    logic             wd_finish_reg;
    logic             busy_reg;
    logic [3:0]       stage_reg;

    logic [L_max-1:0] gen_add1;
    logic [L_max-1:0] gen_add2;
    logic [L_max-2:0] gen_tw;

    fft_bf_addr_gen #(
        .L_max(L_max)
    ) u_addr_gen (
        .s      (s_reg),
        .j      (j_reg),
        .add1   (gen_add1),
        .add2   (gen_add2),
        .tw_addr(gen_tw)
    );

    // Outputs are registered copies of the state one cycle behind, so the
    // read strobe appears the cycle after READ and the write strobe exactly
    // BF_LAT cycles after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            s_reg         <= '0;
            j_reg         <= '0;
            wait_cnt_reg  <= '0;
            rd_en_reg     <= 1'b0;
            rd_add1_reg   <= '0;
            rd_add2_reg   <= '0;
            tw_addr_reg   <= '0;
            wr_en_reg     <= 1'b0;
            wr_add1_reg   <= '0;
            wr_add2_reg   <= '0;
            wd_finish_reg <= 1'b0;
            busy_reg      <= 1'b0;
            stage_reg     <= '0;
        end else begin
            rd_en_reg     <= (state_reg == ST_READ);
            wr_en_reg     <= (state_reg == ST_WRITE);
            wd_finish_reg <= (state_reg == ST_DONE);
            stage_reg     <= s_reg;

            if (state_reg == ST_READ) begin
                rd_add1_reg <= gen_add1;
                rd_add2_reg <= gen_add2;
                tw_addr_reg <= gen_tw;
            end
            if (state_reg == ST_WRITE) begin
                wr_add1_reg <= rd_add1_reg;
                wr_add2_reg <= rd_add2_reg;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (initial_flag) begin
                        s_reg     <= '0;
                        j_reg     <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_READ;
                    end
                end
                ST_READ: begin
                    wait_cnt_reg <= '0;
                    // With a single-cycle datapath there is nothing to wait for.
                    state_reg    <= (BF_LAT == 1) ? ST_WRITE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        state_reg <= ST_WRITE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                ST_WRITE: begin
                    state_reg <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (j_reg != J_LAST) begin
                        j_reg     <= j_reg + 1'b1;
                        state_reg <= ST_READ;
                    end else if (s_reg != S_LAST) begin
                        s_reg     <= s_reg + 4'd1;
                        j_reg     <= '0;
                        state_reg <= ST_READ;
                    end else begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_en     = rd_en_reg;
    assign rd_add1   = rd_add1_reg;
    assign rd_add2   = rd_add2_reg;
    assign tw_addr   = tw_addr_reg;
    assign wr_en     = wr_en_reg;
    assign wr_add1   = wr_add1_reg;
    assign wr_add2   = wr_add2_reg;
    assign wd_finish = wd_finish_reg;
    assign busy      = busy_reg;
    assign stage     = stage_reg;

endmodule

// File: tb/tb_fft_bf_ctrl.sv
// Bench for fft_bf_ctrl: N=8 table run, disturbance and reset sequences,
// a full N=512 run and BF_LAT 1..15 frames against a loop-based pair model.
module tb_fft_bf_ctrl;

    localparam int ND   = 17;
    localparam int MAXB = 2304;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v    [ND];
    logic       flag_v   [ND];
    logic       rd_en_v  [ND];
    logic       wr_en_v  [ND];
    logic       wd_fin_v [ND];
    logic       busy_v   [ND];
    logic [8:0] rd1_v    [ND];
    logic [8:0] rd2_v    [ND];
    logic [8:0] wr1_v    [ND];
    logic [8:0] wr2_v    [ND];
    logic [7:0] tw_v     [ND];
    logic [3:0] stage_v  [ND];

    // dut 0: N=8 BF_LAT=3, dut 1: N=512 BF_LAT=1, duts 2..16: N=16 BF_LAT=1..15
    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        localparam int GL   = (gi == 0) ? 3 : ((gi == 1) ? 9 : 4);
        localparam int GLAT = (gi == 0) ? 3 : ((gi == 1) ? 1 : gi - 1);
        logic [GL-1:0] a1, a2, w1, w2;
        logic [GL-2:0] tw;
        logic          re, we, wf, bz;
        logic [3:0]    st;

        fft_bf_ctrl #(
            .N     (1 << GL),
            .L_max (GL),
            .BF_LAT(GLAT)
        ) u_dut (
            .clk         (clk),
            .rst         (rst_v[gi]),
            .initial_flag(flag_v[gi]),
            .rd_en       (re),
            .rd_add1     (a1),
            .rd_add2     (a2),
            .tw_addr     (tw),
            .wr_en       (we),
            .wr_add1     (w1),
            .wr_add2     (w2),
            .wd_finish   (wf),
            .busy        (bz),
            .stage       (st)
        );

        assign rd_en_v[gi]  = re;
        assign wr_en_v[gi]  = we;
        assign wd_fin_v[gi] = wf;
        assign busy_v[gi]   = bz;
        assign rd1_v[gi]    = 9'(a1);
        assign rd2_v[gi]    = 9'(a2);
        assign wr1_v[gi]    = 9'(w1);
        assign wr2_v[gi]    = 9'(w2);
        assign tw_v[gi]     = 8'(tw);
        assign stage_v[gi]  = st;
    end

    typedef struct {
        int s;
        int j;
        int a;
        int b;
        int tw;
    } vec_t;

    vec_t tab [12];
    int   exp_a [MAXB];
    int   exp_b [MAXB];
    int   exp_t [MAXB];
    int   exp_s [MAXB];
    int   n_cmp;
    int   n_err;

    function automatic int cfg_l(input int d);
        return (d == 0) ? 3 : ((d == 1) ? 9 : 4);
    endfunction

    function automatic int cfg_lat(input int d);
        return (d == 0) ? 3 : ((d == 1) ? 1 : d - 1);
    endfunction

    function automatic int cfg_total(input int d);
        int l;
        l = cfg_l(d);
        return l * ((1 << l) / 2) * (cfg_lat(d) + 2) + 2;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_rd_en"},  int'(rd_en_v[d]),  0);
        chk({tag, "_wr_en"},  int'(wr_en_v[d]),  0);
        chk({tag, "_wd_fin"}, int'(wd_fin_v[d]), 0);
        chk({tag, "_busy"},   int'(busy_v[d]),   0);
        chk({tag, "_rd1"},    int'(rd1_v[d]),    0);
        chk({tag, "_rd2"},    int'(rd2_v[d]),    0);
        chk({tag, "_wr1"},    int'(wr1_v[d]),    0);
        chk({tag, "_wr2"},    int'(wr2_v[d]),    0);
        chk({tag, "_tw"},     int'(tw_v[d]),     0);
        chk({tag, "_stage"},  int'(stage_v[d]),  0);
    endtask

    task automatic load_table();
        for (int i = 0; i < 12; i++) begin
            exp_a[i] = tab[i].a;
            exp_b[i] = tab[i].b;
            exp_t[i] = tab[i].tw;
            exp_s[i] = tab[i].s;
        end
    endtask

    // Stage s splits the frame into groups of 2^(s+1); element m of a group
    // pairs with m + 2^s and uses twiddle m * N / 2^(s+1).
    task automatic build_model(input int d);
        int l, n, k, half, span;
        l = cfg_l(d);
        n = 1 << l;
        k = 0;
        for (int s = 0; s < l; s++) begin
            half = 1 << s;
            span = 2 * half;
            for (int g = 0; g < n; g += span) begin
                for (int m = 0; m < half; m++) begin
                    exp_a[k] = g + m;
                    exp_b[k] = g + m + half;
                    exp_t[k] = m * (n / span);
                    exp_s[k] = s;
                    k++;
                end
            end
        end
    endtask

    // One frame: flag in cycle 0, then every cycle is compared with the
    // expected schedule (read every BF_LAT+2 cycles from cycle 2, write
    // BF_LAT later, wd_finish at the total). f1/f2 add extra flag pulses,
    // rst_at asserts reset in that cycle and abandons the frame.
    task automatic run_frame(input int d, input int f1, input int f2, input int rst_at);
        int l, n, lat, nb, total, k_rd, k_wr, bad, e0, c0, per;
        int wcnt [9][512];
        bit exp_rd, exp_wr;
        l     = cfg_l(d);
        n     = 1 << l;
        lat   = cfg_lat(d);
        nb    = l * n / 2;
        per   = lat + 2;
        total = cfg_total(d);
        k_rd  = 0;
        k_wr  = 0;
        e0    = n_err;
        c0    = n_cmp;
        for (int a = 0; a < 9; a++)
            for (int b = 0; b < 512; b++)
                wcnt[a][b] = 0;

        @(negedge clk);
        flag_v[d] = 1'b1;
        for (int c = 1; c <= total + 4; c++) begin
            @(negedge clk);
            flag_v[d] = (c == f1) || (c == f2);
            exp_rd = (c >= 2) && ((c - 2) % per == 0) && ((c - 2) / per < nb);
            exp_wr = (c >= 2 + lat) && ((c - 2 - lat) % per == 0) && ((c - 2 - lat) / per < nb);
            chk("rd_en", int'(rd_en_v[d]), int'(exp_rd));
            chk("wr_en", int'(wr_en_v[d]), int'(exp_wr));
            chk("rd_wr_overlap", int'(rd_en_v[d] & wr_en_v[d]), 0);
            chk("wd_finish", int'(wd_fin_v[d]), int'(c == total));
            chk("busy", int'(busy_v[d]), int'(c < total));
            if (rd_en_v[d] && k_rd < nb) begin
                chk("rd_add1", int'(rd1_v[d]), exp_a[k_rd]);
                chk("rd_add2", int'(rd2_v[d]), exp_b[k_rd]);
                chk("tw_addr", int'(tw_v[d]), exp_t[k_rd]);
                chk("stage", int'(stage_v[d]), exp_s[k_rd]);
                if (d == 0)
                    $display("  n8 bf %0d: s=%0d rd=(%0d,%0d) tw=%0d", k_rd,
                             stage_v[d], rd1_v[d], rd2_v[d], tw_v[d]);
                k_rd++;
            end
            if (wr_en_v[d] && k_wr < nb) begin
                chk("wr_add1", int'(wr1_v[d]), exp_a[k_wr]);
                chk("wr_add2", int'(wr2_v[d]), exp_b[k_wr]);
                wcnt[exp_s[k_wr]][wr1_v[d]]++;
                wcnt[exp_s[k_wr]][wr2_v[d]]++;
                k_wr++;
            end
            if (c == rst_at) begin
                rst_v[d] = 1'b0;
                #1;
                chk_zero(d, "rst_mid");
                @(negedge clk);
                rst_v[d]  = 1'b1;
                flag_v[d] = 1'b0;
                $display("frame dut=%0d N=%0d BF_LAT=%0d reset at cycle %0d: %0d checks, %0d errors",
                         d, n, lat, c, n_cmp - c0, n_err - e0);
                return;
            end
        end
        chk("rd_count", k_rd, nb);
        chk("wr_count", k_wr, nb);
        bad = 0;
        for (int s = 0; s < l; s++)
            for (int a = 0; a < n; a++)
                if (wcnt[s][a] != 1) bad++;
        chk("write_once_per_stage", bad, 0);
        $display("frame dut=%0d N=%0d BF_LAT=%0d flags@%0d,%0d: %0d checks, %0d errors",
                 d, n, lat, f1, f2, n_cmp - c0, n_err - e0);
    endtask

    initial begin
        int t;
        int f1;
        int f2;
        n_cmp = 0;
        n_err = 0;
        tab[0]  = '{0, 0, 0, 1, 0};
        tab[1]  = '{0, 1, 2, 3, 0};
        tab[2]  = '{0, 2, 4, 5, 0};
        tab[3]  = '{0, 3, 6, 7, 0};
        tab[4]  = '{1, 0, 0, 2, 0};
        tab[5]  = '{1, 1, 1, 3, 2};
        tab[6]  = '{1, 2, 4, 6, 0};
        tab[7]  = '{1, 3, 5, 7, 2};
        tab[8]  = '{2, 0, 0, 4, 0};
        tab[9]  = '{2, 1, 1, 5, 1};
        tab[10] = '{2, 2, 2, 6, 2};
        tab[11] = '{2, 3, 3, 7, 3};
        for (int d = 0; d < ND; d++) begin
            rst_v[d]  = 1'b0;
            flag_v[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) chk_zero(d, "reset");
        $display("reset state checked on %0d instances", ND);
        for (int d = 0; d < ND; d++) rst_v[d] = 1'b1;
        @(negedge clk);

        // N=8 reference sequence, 62-cycle latency
        load_table();
        run_frame(0, -1, -1, -1);
        // extra flag pulses at butterfly 5 and in the first busy cycle
        load_table();
        run_frame(0, 27, 1, -1);
        // flag coincident with DONE must not start a new frame
        load_table();
        run_frame(0, cfg_total(0) - 1, -1, -1);
        // reset during stage-1 WAIT, then a clean frame
        load_table();
        run_frame(0, -1, -1, 28);
        load_table();
        run_frame(0, -1, -1, -1);

        // full-size transform
        build_model(1);
        run_frame(1, -1, -1, -1);

        // every datapath latency, random spurious flags while busy
        for (int d = 2; d < ND; d++) begin
            t  = cfg_total(d);
            f1 = int'($urandom_range(t - 1, 1));
            f2 = int'($urandom_range(t - 1, 1));
            build_model(d);
            run_frame(d, f1, f2, -1);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
